alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Upstream neighbour of the ALU in the single-cycle MIPS datapath.
- Holds the 32x32 register file and decodes the current instruction word.
- Drives the ALU's A, B and ALUctr inputs, plus the store data and destination-register controls used by memory and writeback.
- The only sequential state is the register file, written from writeback at the clock edge.

Parameters:
DATA_W, 32, datapath width; A/B/register width.
NREG, 32, number of architectural registers; register address width is log2(NREG) = 5.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high; clears register file.
instr  in  32  current instruction word (opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0]).
wb_we  in  1  writeback register-write enable.
wb_addr  in  5  writeback destination register.
wb_data  in  32  writeback data.
A  out  32  ALU operand A.
B  out  32  ALU operand B.
ALUctr  out  4  ALU operation code.
store_data  out  32  R[rt], for sw.
dst_addr  out  5  decoded destination: rd for R-type, rt for I-type, 0 otherwise.
dst_we  out  1  decoded register-write request for this instruction.
illegal  out  1  unrecognised opcode/funct.
dbg_addr  in  5  debug read address.
dbg_data  out  32  R[dbg_addr].

Behaviour:
- Register file: 32 x DATA_W, three combinational read ports (rs, rt, dbg) and one synchronous write port.
- Write occurs at the rising clk edge when wb_we=1, wb_addr!=0 and reset=0.
- R0 always reads 0. Writes to R0 are discarded.
- reset=1 at an edge: all registers become 0. A simultaneous wb_we write is ignored. Mid-program reset leaves the registers cleared on the next cycle.
- No write-to-read bypass: a read of the register being written returns the old value until the edge. This is required; bypassing would form a combinational loop through the ALU.
- Decode and outputs are purely combinational from instr and register state (zero cycles of latency). After reset, outputs reflect zeroed registers.
- R-type (opcode 000000), by funct; store_data = R[rt] throughout:
  - add 100000: ALUctr 1110, A=R[rs], B=R[rt].
  - sub 100010: ALUctr 0100, A=R[rs], B=R[rt].
  - and 100100: ALUctr 0010, A=R[rs], B=R[rt].
  - or 100101: ALUctr 0011, A=R[rs], B=R[rt].
  - xor 100110: ALUctr 0111, A=R[rs], B=R[rt].
  - sll 000000: ALUctr 1010, A=zero-extended shamt, B=R[rt].
  - srl 000010: ALUctr 1000, A=zero-extended shamt, B=R[rt].
  - sra 000011: ALUctr 1001, A=zero-extended shamt, B=R[rt].
  - jr 001000: ALUctr 1100, A=R[rs], B=0, dst_we=0.
  - All other R-type: dst_we=1, dst_addr=rd.
- I-type:
  - addi 001000: ALUctr 1110, A=R[rs], B=sign-extended imm.
  - lw 100011: ALUctr 0001, A=R[rs], B=sign-extended imm.
  - sw 101011: ALUctr 0001, A=R[rs], B=sign-extended imm, dst_we=0.
  - andi 001100: ALUctr 0010, A=R[rs], B=zero-extended imm.
  - ori 001101: ALUctr 0011, A=R[rs], B=zero-extended imm.
  - xori 001110: ALUctr 0111, A=R[rs], B=zero-extended imm.
  - beq 000100: ALUctr 0101, A=R[rs], B=R[rt], dst_we=0.
  - lui 001111: ALUctr 0110, A=0, B=zero-extended imm.
  - Writing I-types: dst_addr=rt, dst_we=1.
- Unrecognised opcode or funct: illegal=1, ALUctr=0000, A=B=0, dst_we=0, dst_addr=0.
- dst_we=1 with dst_addr=0 is legal; the write is discarded by the register file.

Decomposition:
- Shared package `mips_defs`: opcode/funct localparams, the 4-bit ALUctr codes listed above (shared with the ALU), and DATA_W.
- One sub-module, `regfile`: 32x32 storage, 2R+1W plus debug read, synchronous reset, R0 hardwired to zero.
- Decode and operand muxing stay in the top.

Test Plan:
- Reset then dbg read of R1..R31 -> all 0x00000000; instr=add $3,$1,$2 -> A=0, B=0, ALUctr=1110, dst_addr=3, dst_we=1.
- Write R1=0x34, R2=0x12 via wb port; instr=sub $3,$1,$2 -> A=0x34, B=0x12, ALUctr=0100.
- Same cycle: wb write R1=0x99 while instr reads rs=1 -> A=0x34 before the edge, 0x99 after it.
- With R2=0xFFFFFFFF, instr=sll $4,$2,3 -> A=0x3, B=0xFFFFFFFF, ALUctr=1010.
- addi $5,$1,0xFFFC -> B=0xFFFFFFFC; andi $5,$1,0xFFFC -> B=0x0000FFFC, ALUctr=0010; sw $2,4($1) -> store_data=R2, dst_we=0.
- wb write to R0 with 0xDEAD -> dbg R0=0; opcode 111111 -> illegal=1, ALUctr=0000, dst_we=0; reset asserted together with wb_we=1 -> register unchanged-to-zero.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// ============================================================================
// Module : mips_defs (package)
// Brief  : Opcode/funct encodings and ALUctr codes shared by decode and ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_defs;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_MEM  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_BEQ  = 4'b0101,
    ALU_LUI  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_JR   = 4'b1100,
    ALU_ADD  = 4'b1110
  } alu_ctr_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

endpackage

`default_nettype wire

// File: rtl/alu_operand_stage_regfile.sv
// ============================================================================
// Module : regfile
// Brief  : NREG x DATA_W register file, 3 combinational reads, 1 sync write.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [$clog2(NREG)-1:0] rs_addr_i,
  input  logic [$clog2(NREG)-1:0] rt_addr_i,
  input  logic [$clog2(NREG)-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]       rs_data_o,
  output logic [DATA_W-1:0]       rt_data_o,
  output logic [DATA_W-1:0]       dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Reads deliberately see the pre-edge value; a bypass would loop through the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs_data_o  = (rs_addr_i  == '0) ? '0 : regs_q[rs_addr_i];
  assign rt_data_o  = (rt_addr_i  == '0) ? '0 : regs_q[rt_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module : alu_operand_stage
// Brief  : Register file plus combinational decode driving ALU operands/ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage #(
  parameter int DATA_W = mips_defs::DATA_W,
  parameter int NREG   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instr,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  output logic [DATA_W-1:0]       A,
  output logic [DATA_W-1:0]       B,
  output logic [3:0]              ALUctr,
  output logic [DATA_W-1:0]       store_data,
  output logic [4:0]              dst_addr,
  output logic                    dst_we,
  output logic                    illegal,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  import mips_defs::*;

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] imm_sext, imm_zext, shamt_zext;
  alu_ctr_e          alu_ctr;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  assign imm_sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext   = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_zext = {{(DATA_W-5){1'b0}}, shamt};

  regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (wb_we),
    .waddr_i    (wb_addr),
    .wdata_i    (wb_data),
    .rs_addr_i  (rs[$clog2(NREG)-1:0]),
    .rt_addr_i  (rt[$clog2(NREG)-1:0]),
    .dbg_addr_i (dbg_addr),
    .rs_data_o  (rs_val),
    .rt_data_o  (rt_val),
    .dbg_data_o (dbg_data)
  );

  assign store_data = rt_val;
  assign ALUctr     = alu_ctr;

  always_comb begin
    alu_ctr  = ALU_NONE;
    A        = '0;
    B        = '0;
    dst_we   = 1'b0;
    dst_addr = '0;
    illegal  = 1'b0;
    if (opcode == OP_RTYPE) begin
      A        = rs_val;
      B        = rt_val;
      dst_we   = 1'b1;
      dst_addr = rd;
      case (funct)
        FN_ADD:  alu_ctr = ALU_ADD;
        FN_SUB:  alu_ctr = ALU_SUB;
        FN_AND:  alu_ctr = ALU_AND;
        FN_OR:   alu_ctr = ALU_OR;
        FN_XOR:  alu_ctr = ALU_XOR;
        FN_SLL:  begin alu_ctr = ALU_SLL; A = shamt_zext; end
        FN_SRL:  begin alu_ctr = ALU_SRL; A = shamt_zext; end
        FN_SRA:  begin alu_ctr = ALU_SRA; A = shamt_zext; end
        FN_JR:   begin alu_ctr = ALU_JR;  B = '0; dst_we = 1'b0; end
        default: begin
          A        = '0;
          B        = '0;
          dst_we   = 1'b0;
          dst_addr = '0;
          illegal  = 1'b1;
        end
      endcase
    end else begin
      A        = rs_val;
      dst_we   = 1'b1;
      dst_addr = rt;
      case (opcode)
        OP_ADDI: begin alu_ctr = ALU_ADD; B = imm_sext; end
        OP_LW:   begin alu_ctr = ALU_MEM; B = imm_sext; end
        OP_SW:   begin alu_ctr = ALU_MEM; B = imm_sext; dst_we = 1'b0; end
        OP_ANDI: begin alu_ctr = ALU_AND; B = imm_zext; end
        OP_ORI:  begin alu_ctr = ALU_OR;  B = imm_zext; end
        OP_XORI: begin alu_ctr = ALU_XOR; B = imm_zext; end
        OP_BEQ:  begin alu_ctr = ALU_BEQ; B = rt_val;   dst_we = 1'b0; end
        OP_LUI:  begin alu_ctr = ALU_LUI; A = '0; B = imm_zext; end
        default: begin
          A        = '0;
          dst_we   = 1'b0;
          dst_addr = '0;
          illegal  = 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
